// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues one word-addressed read at a time and
// buffers returned instructions in a small FIFO toward the core.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready
);

    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic             outstanding_q, outstanding_d;
    logic             discard_q, discard_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

    logic [31:0] pc_mem    [QDEPTH];
    logic [31:0] instr_mem [QDEPTH];

    logic [31:0] inflight;
    logic        grant;
    logic        resp;
    logic        push;
    logic        pop;

    // Reserve a queue slot for the in-flight request so a response can always be stored.
    assign inflight = 32'(count_q) + 32'(outstanding_q);

    always_comb begin
        imem_req  = reset_n && !redirect && (!outstanding_q || imem_rvalid) &&
                    (inflight < QDEPTH);
        imem_addr = fetch_pc_q;
        grant     = imem_req && imem_gnt;
        resp      = imem_rvalid && outstanding_q;
        push      = resp && !discard_q && !redirect;
        if_valid  = (count_q != '0);
        pop       = if_valid && if_ready && !redirect;
        if_instr  = instr_mem[rd_ptr_q];
        if_pc     = pc_mem[rd_ptr_q];
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (grant) begin
            outstanding_d = 1'b1;
            req_pc_d      = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + 32'd1;
        end else if (resp) begin
            outstanding_d = 1'b0;
        end

        if (resp && discard_q) begin
            discard_d = 1'b0;
        end

        if (redirect) begin
            fetch_pc_d = redirect_pc;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            // A response still in flight belongs to the old stream; mark it for dropping.
            if (outstanding_q && !imem_rvalid) begin
                discard_d = 1'b1;
            end
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= RESET_PC;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clock) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= req_pc_q;
            instr_mem[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table-driven cycle vectors for streaming and
// back-pressure, plus hand sequences for redirect, PC wrap and mid-run reset.
module tb_fetch_unit;

    logic        clock;
    logic        reset_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;

    int checks   = 0;
    int failures = 0;

    fetch_unit #(
        .RESET_PC (32'h0),
        .QDEPTH   (4)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_ready    (if_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) + 32'h1234_5678;
    endfunction

    // Memory model: one read in flight, data returned `lat` cycles after grant.
    int          lat = 1;
    logic        rs_g;
    logic [31:0] rs_ga;
    logic [31:0] rs_addr;
    int          rs_cnt  = 0;
    bit          rs_pend = 1'b0;

    always begin
        @(negedge clock);
        rs_g  = imem_req && imem_gnt;
        rs_ga = imem_addr;
        @(posedge clock);
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hBAD0_BAD0;
        if (rs_g) begin
            rs_pend = 1'b1;
            rs_cnt  = lat;
            rs_addr = rs_ga;
        end
        if (rs_pend) begin
            rs_cnt = rs_cnt - 1;
            if (rs_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(rs_addr);
                rs_pend     = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        redirect = 1'b0;
        repeat (5) step();
        reset_n = 1'b1;
    endtask

    // Waits (bounded) for the next valid head and checks its pc and instruction.
    task automatic wait_valid(input logic [31:0] exp_pc, input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            #4;
            if (if_valid) begin
                chk({name, " if_pc"}, if_pc, exp_pc);
                chk({name, " if_instr"}, if_instr, mem_word(exp_pc));
                seen = 1'b1;
            end
            step();
        end
        if (!seen) begin
            chk({name, " timeout if_valid"}, 32'(if_valid), 32'd1);
        end
    endtask

    typedef struct {
        bit          do_reset;
        bit          ready;
        bit          exp_valid;
        logic [31:0] exp_pc;
        bit          exp_req;
        logic [31:0] exp_addr;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic set_vec(input int i, input bit rst, input bit rdy, input bit v,
                           input logic [31:0] pc, input bit rq, input logic [31:0] a);
        vecs[i] = '{rst, rdy, v, pc, rq, a};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if_ready    = 1'b0;

        // Streaming: gnt=1, 1-cycle latency, always ready.
        set_vec(0, 1, 1, 0, 32'h0, 1, 32'h0);
        set_vec(1, 0, 1, 0, 32'h0, 1, 32'h1);
        set_vec(2, 0, 1, 1, 32'h0, 1, 32'h2);
        set_vec(3, 0, 1, 1, 32'h1, 1, 32'h3);
        set_vec(4, 0, 1, 1, 32'h2, 1, 32'h4);
        set_vec(5, 0, 1, 1, 32'h3, 1, 32'h5);
        // Back-pressure for 10 cycles, queue fills, then drains in order.
        set_vec(6, 1, 0, 0, 32'h0, 1, 32'h0);
        set_vec(7, 0, 0, 0, 32'h0, 1, 32'h1);
        set_vec(8, 0, 0, 1, 32'h0, 1, 32'h2);
        set_vec(9, 0, 0, 1, 32'h0, 1, 32'h3);
        for (int i = 10; i < 16; i++) set_vec(i, 0, 0, 1, 32'h0, 0, 32'h0);
        set_vec(16, 0, 1, 1, 32'h0, 0, 32'h0);
        set_vec(17, 0, 1, 1, 32'h1, 1, 32'h4);
        set_vec(18, 0, 1, 1, 32'h2, 1, 32'h5);
        set_vec(19, 0, 1, 1, 32'h3, 1, 32'h6);
        set_vec(20, 0, 1, 1, 32'h4, 1, 32'h7);

        #3;
        chk("reset if_valid", 32'(if_valid), 32'd0);
        chk("reset imem_req", 32'(imem_req), 32'd0);
        step();

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].do_reset) do_reset();
            if_ready = vecs[i].ready;
            #4;
            chk($sformatf("vec%0d if_valid", i), 32'(if_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d if_pc", i), if_pc, vecs[i].exp_pc);
                chk($sformatf("vec%0d if_instr", i), if_instr, mem_word(vecs[i].exp_pc));
            end
            chk($sformatf("vec%0d imem_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
            if (vecs[i].exp_req) begin
                chk($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].exp_addr);
            end
            step();
        end

        // Redirect while a 3-cycle read is outstanding: stale data must be dropped.
        lat      = 3;
        if_ready = 1'b1;
        do_reset();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        #4;
        chk("redir_out imem_req", 32'(imem_req), 32'd0);
        step();
        redirect = 1'b0;
        #4;
        chk("redir_out if_valid after", 32'(if_valid), 32'd0);
        step();
        wait_valid(32'h40, "redir_out first");
        wait_valid(32'h41, "redir_out second");

        // Redirect coinciding with rvalid and a pop.
        lat = 1;
        do_reset();
        step();
        step();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        #4;
        chk("redir_rv head valid", 32'(if_valid), 32'd1);
        chk("redir_rv imem_req", 32'(imem_req), 32'd0);
        step();
        redirect = 1'b0;
        #4;
        chk("redir_rv if_valid after", 32'(if_valid), 32'd0);
        step();
        wait_valid(32'h80, "redir_rv first");
        wait_valid(32'h81, "redir_rv second");

        // PC wrap at the top of the address space.
        do_reset();
        step();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        step();
        redirect = 1'b0;
        wait_valid(32'hFFFF_FFFF, "wrap top");
        wait_valid(32'h0, "wrap zero");

        // Reset pulse with one read outstanding and two entries queued.
        lat      = 4;
        if_ready = 1'b0;
        do_reset();
        repeat (9) step();
        #1;
        chk("rst_mid pre if_valid", 32'(if_valid), 32'd1);
        chk("rst_mid pre if_pc", if_pc, 32'h0);
        reset_n  = 1'b0;
        imem_gnt = 1'b0;
        #1;
        chk("rst_mid if_valid", 32'(if_valid), 32'd0);
        chk("rst_mid imem_req", 32'(imem_req), 32'd0);
        step();
        reset_n = 1'b1;
        #4;
        chk("rst_mid refetch req", 32'(imem_req), 32'd1);
        chk("rst_mid refetch addr", imem_addr, 32'h0);
        step();
        for (int k = 0; k < 4; k++) begin
            #4;
            chk($sformatf("rst_mid late rvalid cyc%0d if_valid", k), 32'(if_valid), 32'd0);
            step();
        end
        imem_gnt = 1'b1;
        lat      = 1;
        if_ready = 1'b1;
        wait_valid(32'h0, "rst_mid first");
        wait_valid(32'h1, "rst_mid second");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0, the word-addressed PC loaded on reset.
REQ-002 The block SHALL have parameter QDEPTH, default 4, the instruction queue depth (power of 2, >=2).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have port clock  in  1  rising-edge clock.
REQ-005 The block SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-006 The block SHALL have port redirect  in  1  jump/branch/jr taken; flush and refetch.
REQ-007 The block SHALL have port redirect_pc  in  32  new word-addressed PC.
REQ-008 The block SHALL have port imem_req  out  1  instruction memory read request.
REQ-009 The block SHALL have port imem_addr  out  32  word address of the request.
REQ-010 The block SHALL have port imem_gnt  in  1  request accepted when imem_req&imem_gnt.
REQ-011 The block SHALL have port imem_rvalid  in  1  read data valid, >=1 cycle after grant.
REQ-012 The block SHALL have port imem_rdata  in  32  instruction word.
REQ-013 The block SHALL have port if_valid  out  1  queue head valid toward the core.
REQ-014 The block SHALL have port if_instr  out  32  head instruction.
REQ-015 The block SHALL have port if_pc  out  32  PC of the head instruction.
REQ-016 The block SHALL have port if_ready  in  1  core accepts head when if_valid&if_ready.

Function
REQ-017 State: fetch_pc (32), outstanding (1), req_pc (32), discard (1), queue of QDEPTH {pc,instr} entries, count (0..QDEPTH).
REQ-018 imem_req SHALL be combinational: !redirect & (!outstanding | imem_rvalid) & (count + outstanding < QDEPTH); imem_addr = fetch_pc.
REQ-019 On imem_req&imem_gnt: outstanding<=1, req_pc<=fetch_pc, fetch_pc<=fetch_pc+1 modulo 2^32 (32'hFFFFFFFF wraps to 0).
REQ-020 At most one request SHALL be outstanding; the memory tolerates imem_req withdrawn before grant.
REQ-021 On imem_rvalid with outstanding=1 and discard=0 (no redirect): push {req_pc, imem_rdata}; clear outstanding unless a new grant occurs the same cycle.
REQ-022 On imem_rvalid with discard=1: drop data, clear discard and outstanding.
REQ-023 imem_rvalid with outstanding=0 SHALL be ignored.
REQ-024 if_valid = (count != 0); if_instr/if_pc = head entry; pop on if_valid&if_ready.
REQ-025 Push and pop in the same cycle SHALL be allowed, count unchanged; overflow is impossible by REQ-018.
REQ-026 if_instr/if_pc SHALL be stable while if_valid&!if_ready.
REQ-027 Redirect SHALL take precedence over push, pop and grant: count<=0, fetch_pc<=redirect_pc, imem_req=0 that cycle.
REQ-028 Redirect with outstanding=1 and no imem_rvalid that cycle: discard<=1; with imem_rvalid the same cycle: data dropped, outstanding<=0.
REQ-029 if_valid SHALL be 0 the cycle after redirect; first request to redirect_pc issues the cycle after redirect.
REQ-030 Steady-state throughput with imem_gnt=1, 1-cycle read latency, if_ready=1: one instruction per cycle.

Reset
REQ-031 reset_n low SHALL asynchronously set fetch_pc=RESET_PC, count=0, outstanding=0, discard=0, if_valid=0, imem_req=0.
REQ-032 Reset mid-operation SHALL abandon any outstanding request; a response arriving after release with outstanding=0 is ignored.
REQ-033 First request SHALL issue the first cycle after reset_n rises, with imem_addr=RESET_PC.

Verification
REQ-034 Reset release, gnt=1, 1-cycle latency, if_ready=1 -> if_pc 0,1,2,3 on consecutive cycles, if_instr matches memory.
REQ-035 if_ready=0 for 10 cycles -> queue fills to 4 entries, imem_req low, head pc=0 held stable; if_ready=1 -> pcs 0..3 in order, no loss or duplicate.
REQ-036 Redirect to 32'h40 with a request outstanding (3-cycle latency) -> stale response dropped, next if_pc=32'h40, then 32'h41.
REQ-037 Redirect in the same cycle as imem_rvalid and pop -> queue empty next cycle, no stale entry delivered.
REQ-038 redirect_pc=32'hFFFFFFFF -> if_pc FFFFFFFF followed by 0.
REQ-039 reset_n pulsed low with a request outstanding and 2 queued entries -> if_valid=0 immediately, late rvalid ignored, refetch from RESET_PC.
